// File: rtl/mem_responder.sv
// Memory responder for the 16-bit-address / 32-bit-data memory port.
// A request is accepted only in IDLE. The responder waits a fixed number of
// cycles, performs the access, and then raises ready for one cycle.
// Misaligned or out-of-range accesses fault: err is raised with ready, no
// write is made, and a faulting read returns zero.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT4   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    enter_resp;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [31:0]             acc_wdata;
    logic [IDX_W-1:0]        acc_idx;
    logic                    acc_fault;
    logic [MEM_AW-1:0]       mem_idx;
    logic                    mem_wr;

    logic [31:0]             mem_q [DEPTH_WORDS];

    // Access operands: with zero latency the access happens on the accept
    // edge itself, so the live inputs are used instead of the captured copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_idx   = acc_addr[ADDR_WIDTH-1:2];
        mem_idx   = acc_idx[MEM_AW-1:0];
        acc_fault = (acc_addr[1:0] != 2'b00) || (32'(acc_idx) >= DEPTH_WORDS);
    end

    // Next-state logic: capture in IDLE, count down in WAIT, one-cycle RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = LAT4;
                    if (LAT4 == 4'd0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response data and fault flag are produced on the edge entering RESP.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = enter_resp & acc_fault;
        if (enter_resp && !acc_we) begin
            rdata_d = acc_fault ? '0 : mem_q[mem_idx];
        end
    end

    // Gating with reset keeps an edge seen under reset from committing a write.
    assign mem_wr = enter_resp & acc_we & ~acc_fault & reset;

    // Control and response registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Word storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[mem_idx] <= acc_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ready = (state_q == S_RESP);
    assign busy  = (state_q != S_IDLE);
    assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 0 and 2) share one set of
// inputs and are checked every cycle against a transaction-level model.
module tb_mem_responder;

    localparam int unsigned L0 = 0;
    localparam int unsigned L1 = 2;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;

    wire  [31:0] rdata0, rdata1;
    wire         ready0, ready1, busy0, busy1, err0, err1;

    int checks   = 0;
    int failures = 0;

    mem_responder #(.ADDR_WIDTH(16), .DEPTH_WORDS(1024), .LATENCY(L0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    mem_responder #(.ADDR_WIDTH(16), .DEPTH_WORDS(1024), .LATENCY(L1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_of(input int i);
        return (i == 0) ? rdata0 : rdata1;
    endfunction
    function automatic logic rdy_of(input int i);
        return (i == 0) ? ready0 : ready1;
    endfunction
    function automatic logic bsy_of(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction
    function automatic logic err_of(input int i);
        return (i == 0) ? err0 : err1;
    endfunction
    function automatic int lat_of(input int i);
        return (i == 0) ? int'(L0) : int'(L1);
    endfunction

    // ---------------- transaction-level model ----------------
    int          ecount = 0;
    bit          m_busy   [2];
    bit          m_ready  [2];
    bit          m_err    [2];
    bit          m_rknown [2];
    logic [31:0] m_rdata  [2];
    int          m_resp_edge [2];
    bit          c_we    [2];
    logic [15:0] c_addr  [2];
    logic [31:0] c_wdata [2];
    bit   [31:0] memm [int];

    task automatic perform(input int i);
        int  idx;
        int  key;
        bit  fault;
        idx   = int'(c_addr[i] >> 2);
        key   = i * 65536 + idx;
        fault = (c_addr[i] % 4 != 0) || (idx >= 1024);
        m_ready[i] = 1'b1;
        m_err[i]   = fault;
        if (c_we[i]) begin
            if (!fault) memm[key] = c_wdata[i];
        end else if (fault) begin
            m_rdata[i]  = 32'h0;
            m_rknown[i] = 1'b1;
        end else if (memm.exists(key)) begin
            m_rdata[i]  = memm[key];
            m_rknown[i] = 1'b1;
        end else begin
            m_rknown[i] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i]   = 1'b0;
                m_ready[i]  = 1'b0;
                m_err[i]    = 1'b0;
                m_rdata[i]  = 32'h0;
                m_rknown[i] = 1'b1;
            end
        end else begin
            ecount++;
            for (int i = 0; i < 2; i++) begin
                if (m_ready[i]) begin
                    m_ready[i] = 1'b0;
                    m_busy[i]  = 1'b0;
                    m_err[i]   = 1'b0;
                end else begin
                    if (!m_busy[i] && req) begin
                        m_busy[i]      = 1'b1;
                        c_we[i]        = we;
                        c_addr[i]      = addr;
                        c_wdata[i]     = wdata;
                        m_resp_edge[i] = ecount + lat_of(i);
                    end
                    if (m_busy[i] && ecount == m_resp_edge[i]) perform(i);
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready[%0d]", i), 32'(rdy_of(i)), 32'(m_ready[i]));
            chk($sformatf("busy[%0d]", i),  32'(bsy_of(i)), 32'(m_busy[i]));
            chk($sformatf("err[%0d]", i),   32'(err_of(i)), 32'(m_err[i]));
            if (m_rknown[i]) chk($sformatf("rdata[%0d]", i), rd_of(i), m_rdata[i]);
        end
    end

    // ---------------- directed helpers ----------------
    int          t_lat [2];
    logic [31:0] t_rd  [2];
    logic        t_er  [2];

    task automatic txn(input bit w, input logic [15:0] a, input logic [31:0] d);
        bit seen [2];
        bit done;
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        done    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_lat[i] = -1;
            t_rd[i]  = 'x;
            t_er[i]  = 1'bx;
        end
        @(negedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int n = 1; n <= 30 && !done; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!seen[i] && rdy_of(i)) begin
                    seen[i]  = 1'b1;
                    t_lat[i] = n;
                    t_rd[i]  = rd_of(i);
                    t_er[i]  = err_of(i);
                end
            end
            if (seen[0] && seen[1] && !busy0 && !busy1) done = 1'b1;
            if (n == 1) begin #1; req = 1'b0; end
        end
        if (!done) chk("txn_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (!busy0 && !busy1) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt0;
        int cnt1;
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

        // Reset values, held and after release.
        repeat (3) @(negedge clk);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_flags0", {29'b0, ready0, busy0, err0}, 32'h0);
        chk("rst_flags1", {29'b0, ready1, busy1, err1}, 32'h0);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_rdata1", rdata1, 32'h0);
        chk("post_rst_flags1", {29'b0, ready1, busy1, err1}, 32'h0);

        // Write then read back.
        txn(1'b1, 16'h0010, 32'hDEADBEEF);
        chk("wr_lat1", 32'(t_lat[1]), 32'd3);
        chk("wr_lat0", 32'(t_lat[0]), 32'd1);
        chk("wr_err1", 32'(t_er[1]), 32'd0);
        txn(1'b0, 16'h0010, 32'h0);
        chk("rd_lat1", 32'(t_lat[1]), 32'd3);
        chk("rd_data1", t_rd[1], 32'hDEADBEEF);
        chk("rd_data0", t_rd[0], 32'hDEADBEEF);
        chk("rd_err1", 32'(t_er[1]), 32'd0);

        // Misaligned write faults and leaves storage untouched.
        txn(1'b1, 16'h0012, 32'h12345678);
        chk("mis_err1", 32'(t_er[1]), 32'd1);
        chk("mis_err0", 32'(t_er[0]), 32'd1);
        txn(1'b0, 16'h0010, 32'h0);
        chk("mis_rd1", t_rd[1], 32'hDEADBEEF);

        // Out-of-range read faults with zero data.
        txn(1'b0, 16'h1000, 32'h0);
        chk("oor_err1", 32'(t_er[1]), 32'd1);
        chk("oor_rd1", t_rd[1], 32'h0);
        chk("oor_rd0", t_rd[0], 32'h0);

        // Request held high: one response per accept, idle cycle in between.
        cnt0 = 0; cnt1 = 0;
        @(negedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 16'h0010;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ready0) cnt0++;
            if (ready1) cnt1++;
        end
        #1 req = 1'b0;
        chk("held_cnt1", 32'(cnt1), 32'd3);
        chk("held_cnt0", 32'(cnt0), 32'd6);
        wait_idle();

        // Reset during WAIT aborts the write.
        txn(1'b1, 16'h0020, 32'h11111111);
        @(negedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("mid_busy1", 32'(busy1), 32'd1);
        chk("mid_ready1", 32'(ready1), 32'd0);
        #1 req = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_flags1", {29'b0, ready1, busy1, err1}, 32'h0);
        #1 reset = 1'b1;
        txn(1'b0, 16'h0020, 32'h0);
        chk("mid_rd1", t_rd[1], 32'h11111111);
        chk("mid_rd0", t_rd[0], 32'hCAFEF00D);
        chk("mid_lat1", 32'(t_lat[1]), 32'd3);

        // Seed the random address pool so every in-range read is defined.
        for (int k = 0; k < 8; k++) txn(1'b1, 16'(16'h0040 + 4 * k), $urandom);

        // Random traffic, including input changes while busy and stray resets.
        for (int n = 0; n < 2000; n++) begin
            int r;
            @(negedge clk); #1;
            reset = ($urandom_range(0, 79) != 0);
            req   = ($urandom_range(0, 2) != 0);
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            r     = $urandom_range(0, 9);
            if (r < 8)       addr = 16'(16'h0040 + 4 * r);
            else if (r == 8) addr = 16'(16'h0040 + 4 * $urandom_range(0, 7) + $urandom_range(1, 3));
            else             addr = 16'(16'h1000 + 4 * $urandom_range(0, 1000));
        end
        @(negedge clk); #1;
        reset = 1'b1; req = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
